// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled dual-port RAM.
// Used by the top level and the clear sequencer.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  function automatic int nbytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear engine: walks every word once, writing the fill value.
// Runs after reset (optional) or on a one-cycle request.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  clr_state_t      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  // Next state: requests only accepted when idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        cnt_d = '0;
        if (clr_req) state_d = CLR_RUN;
      end
      CLR_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // State register; reset aborts any clear in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == CLR_RUN);
  assign clr_we   = busy && !reset;
  assign clr_addr = cnt_q[ADDR_W-1:0];
  assign clr_done = done_q;

endmodule

// File: rtl/ram_dp_be.sv
// True dual-port RAM with byte enables, selectable read-during-write,
// optional output register and a fill engine that owns both ports.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int                ADDR_W         = 11,
  parameter int                DATA_W         = 8,
  parameter int                BYTE_W         = 8,
  parameter int                RDW_MODE       = 0,
  parameter int                OUT_REG        = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE      = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_clken,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     a_wren,
  input  logic [DATA_W/BYTE_W-1:0] a_byteen,
  output logic [DATA_W-1:0]        a_q,
  input  logic                     b_clken,
  input  logic [ADDR_W-1:0]        b_address,
  input  logic [DATA_W-1:0]        b_data,
  input  logic                     b_wren,
  input  logic [DATA_W/BYTE_W-1:0] b_byteen,
  output logic [DATA_W-1:0]        b_q,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int NBYTES = nbytes(DATA_W, BYTE_W);
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET != 0)
  ) u_clr (
    .clock   (clock),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic              a_re, b_re, a_we, b_we;
  logic [DATA_W-1:0] a_wm, b_wm;
  logic [DATA_W-1:0] a_old, b_old;
  logic [DATA_W-1:0] a_base, a_new, b_new;
  logic [DATA_W-1:0] a_r_d, b_r_d;
  logic [DATA_W-1:0] a_r_q, b_r_q, a_o_q, b_o_q;
  logic              a_en_q, b_en_q;

  assign a_re = a_clken && !busy;
  assign b_re = b_clken && !busy;
  assign a_we = a_re && a_wren && !reset;
  assign b_we = b_re && b_wren && !reset;

  // Expand byte enables into bit masks
  always_comb begin
    a_wm = '0;
    b_wm = '0;
    for (int i = 0; i < NBYTES; i++) begin
      a_wm[i*BYTE_W +: BYTE_W] = {BYTE_W{a_we && a_byteen[i]}};
      b_wm[i*BYTE_W +: BYTE_W] = {BYTE_W{b_we && b_byteen[i]}};
    end
  end

  assign a_old = mem[a_address];
  assign b_old = mem[b_address];

  // B merges into the old word; A merges on top so it wins overlaps
  assign b_new  = (b_old & ~b_wm) | (b_data & b_wm);
  assign a_base = (b_we && b_address == a_address) ? b_new : a_old;
  assign a_new  = (a_base & ~a_wm) | (a_data & a_wm);

  // Same-port forwarding only; the other port's write is never seen
  assign a_r_d = (RDW_MODE == RDW_NEW)
               ? ((a_old & ~a_wm) | (a_data & a_wm)) : a_old;
  assign b_r_d = (RDW_MODE == RDW_NEW)
               ? ((b_old & ~b_wm) | (b_data & b_wm)) : b_old;

  // Storage update; clear engine overrides both user ports
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VALUE;
    end else begin
      if (b_we) mem[b_address] <= b_new;
      if (a_we) mem[a_address] <= a_new;
    end
  end

  // Read capture plus optional second output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      a_r_q  <= '0;
      b_r_q  <= '0;
      a_o_q  <= '0;
      b_o_q  <= '0;
      a_en_q <= 1'b0;
      b_en_q <= 1'b0;
    end else begin
      if (a_re)   a_r_q <= a_r_d;
      if (b_re)   b_r_q <= b_r_d;
      if (a_en_q) a_o_q <= a_r_q;
      if (b_en_q) b_o_q <= b_r_q;
      a_en_q <= a_re;
      b_en_q <= b_re;
    end
  end

  assign a_q = (OUT_REG != 0) ? a_o_q : a_r_q;
  assign b_q = (OUT_REG != 0) ? b_o_q : b_r_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two configurations share one stimulus stream
// and are compared every cycle against a word-array reference model.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_en = 0, a_we = 0, b_en = 0, b_we = 0, creq = 0;
  logic [3:0]  a_ad = 0, b_ad = 0;
  logic [15:0] a_dat = 0, b_dat = 0;
  logic [1:0]  a_be = 0, b_be = 0;

  logic [15:0] q0a, q0b, q1a, q1b;
  logic        busy0, done0, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_dp_be #(
    .ADDR_W(4), .DATA_W(16), .BYTE_W(8), .RDW_MODE(1),
    .OUT_REG(0), .CLEAR_ON_RESET(1), .CLR_VALUE(16'hA5A5)
  ) u0 (
    .clock(clk), .reset(rst),
    .a_clken(a_en), .a_address(a_ad), .a_data(a_dat),
    .a_wren(a_we), .a_byteen(a_be), .a_q(q0a),
    .b_clken(b_en), .b_address(b_ad), .b_data(b_dat),
    .b_wren(b_we), .b_byteen(b_be), .b_q(q0b),
    .clr_req(creq), .busy(busy0), .clr_done(done0)
  );

  ram_dp_be #(
    .ADDR_W(4), .DATA_W(16), .BYTE_W(8), .RDW_MODE(0),
    .OUT_REG(1), .CLEAR_ON_RESET(1), .CLR_VALUE(16'h00A5)
  ) u1 (
    .clock(clk), .reset(rst),
    .a_clken(a_en), .a_address(a_ad), .a_data(a_dat),
    .a_wren(a_we), .a_byteen(a_be), .a_q(q1a),
    .b_clken(b_en), .b_address(b_ad), .b_data(b_dat),
    .b_wren(b_we), .b_byteen(b_be), .b_q(q1b),
    .clr_req(creq), .busy(busy1), .clr_done(done1)
  );

  // Reference model state, one slot per configuration
  logic [15:0] mm [2][16];
  logic [15:0] rqa[2], rqb[2], oqa[2], oqb[2];
  bit          ena[2], enb[2], dn[2];
  int          left[2];

  function automatic bit mode_new(input int d);
    return d == 0;
  endfunction

  function automatic bit has_oreg(input int d);
    return d == 1;
  endfunction

  function automatic logic [15:0] clrv(input int d);
    return (d == 0) ? 16'hA5A5 : 16'h00A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int d);
    logic [15:0] wa, wb, oa, ob;
    if (rst) begin
      rqa[d] = 0; rqb[d] = 0; oqa[d] = 0; oqb[d] = 0;
      ena[d] = 0; enb[d] = 0; dn[d] = 0; left[d] = 16;
    end else if (left[d] > 0) begin
      mm[d][16-left[d]] = clrv(d);
      left[d]--;
      dn[d] = (left[d] == 0);
      if (ena[d]) oqa[d] = rqa[d];
      if (enb[d]) oqb[d] = rqb[d];
      ena[d] = 0;
      enb[d] = 0;
    end else begin
      dn[d] = 0;
      wa = (a_en && a_we) ? {{8{a_be[1]}}, {8{a_be[0]}}} : 16'h0;
      wb = (b_en && b_we) ? {{8{b_be[1]}}, {8{b_be[0]}}} : 16'h0;
      oa = mm[d][a_ad];
      ob = mm[d][b_ad];
      if (ena[d]) oqa[d] = rqa[d];
      if (enb[d]) oqb[d] = rqb[d];
      if (a_en) rqa[d] = mode_new(d) ? ((oa & ~wa) | (a_dat & wa)) : oa;
      if (b_en) rqb[d] = mode_new(d) ? ((ob & ~wb) | (b_dat & wb)) : ob;
      mm[d][b_ad] = (ob & ~wb) | (b_dat & wb);
      mm[d][a_ad] = (mm[d][a_ad] & ~wa) | (a_dat & wa);
      ena[d] = a_en;
      enb[d] = b_en;
      if (creq) left[d] = 16;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
    chk("u0_a_q", q0a, has_oreg(0) ? oqa[0] : rqa[0]);
    chk("u0_b_q", q0b, has_oreg(0) ? oqb[0] : rqb[0]);
    chk("u0_busy", busy0, left[0] > 0);
    chk("u0_done", done0, dn[0]);
    chk("u1_a_q", q1a, has_oreg(1) ? oqa[1] : rqa[1]);
    chk("u1_b_q", q1b, has_oreg(1) ? oqb[1] : rqb[1]);
    chk("u1_busy", busy1, left[1] > 0);
    chk("u1_done", done1, dn[1]);
  endtask

  task automatic idle();
    a_en = 0; a_we = 0; b_en = 0; b_we = 0; creq = 0;
    a_be = 0; b_be = 0;
  endtask

  // Counts busy cycles and done pulses; writes are thrown at it early
  task automatic run_clear(input string tag, input int poke);
    int bc = 0;
    int dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) bc++;
      if (done0) dc++;
      creq = (i == poke);
      if (i < 10) begin
        a_en = 1; a_we = 1; a_be = 2'b11;
        a_ad = 4'($urandom_range(15)); a_dat = 16'($urandom);
        b_en = 1; b_we = 1; b_be = 2'b11;
        b_ad = 4'($urandom_range(15)); b_dat = 16'($urandom);
      end else begin
        idle();
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, bc, 16);
    chk({tag, "_done_pulses"}, dc, 1);
  endtask

  task automatic read_all(input logic [15:0] fill);
    for (int i = 0; i < 16; i++) begin
      a_en = 1; a_we = 0; a_ad = 4'(i);
      b_en = 1; b_we = 0; b_ad = 4'(15 - i);
      tick();
      chk("fill_rd", q0a, fill);
    end
    idle();
  endtask

  task automatic wr_a(input logic [3:0] ad, input logic [15:0] dat,
                      input logic [1:0] be);
    a_en = 1; a_we = 1; a_ad = ad; a_dat = dat; a_be = be;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    run_clear("por", -1);
    read_all(16'hA5A5);

    wr_a(4'd3, 16'hFFFF, 2'b11);
    tick();
    wr_a(4'd3, 16'h1234, 2'b01);
    tick();
    idle();
    b_en = 1; b_ad = 4'd3;
    tick();
    chk("be_merge", q0b, 16'hFF34);

    idle();
    wr_a(4'd5, 16'h1111, 2'b11);
    tick();
    wr_a(4'd5, 16'h2222, 2'b11);
    tick();
    chk("rdw_new", q0a, 16'h2222);
    a_we = 0;
    tick();
    chk("rdw_next", q0a, 16'h2222);
    chk("rdw_old_oreg", q1a, 16'h1111);

    wr_a(4'd7, 16'hAAAA, 2'b11);
    b_en = 1; b_we = 1; b_ad = 4'd7; b_dat = 16'h5555; b_be = 2'b11;
    tick();
    idle();
    a_en = 1; a_ad = 4'd7;
    tick();
    chk("coll_ww", q0a, 16'hAAAA);
    wr_a(4'd7, 16'h3C3C, 2'b11);
    b_en = 1; b_we = 0; b_ad = 4'd7;
    tick();
    chk("coll_rw", q0b, 16'hAAAA);

    idle();
    wr_a(4'd8, 16'h1111, 2'b01);
    b_en = 1; b_we = 1; b_ad = 4'd8; b_dat = 16'h2222; b_be = 2'b11;
    tick();
    idle();
    a_en = 1; a_ad = 4'd8;
    tick();
    chk("coll_part", q0a, 16'h2211);

    idle();
    wr_a(4'd2, 16'h0077, 2'b11);
    tick();
    a_we = 0;
    tick();
    a_en = 0;
    tick();
    chk("oreg_lat2", q1a, 16'h0077);
    tick();
    chk("oreg_hold", q1a, 16'h0077);

    idle();
    creq = 1;
    tick();
    run_clear("req2", 5);
    read_all(16'hA5A5);

    wr_a(4'd9, 16'h4242, 2'b11);
    tick();
    idle();
    creq = 1;
    tick();
    creq = 0;
    repeat (6) tick();
    rst = 1;
    tick();
    rst = 0;
    run_clear("rst6", -1);
    read_all(16'hA5A5);

    for (int i = 0; i < 600; i++) begin
      a_en = 1'($urandom); a_we = 1'($urandom);
      a_ad = 4'($urandom_range(15)); a_dat = 16'($urandom);
      a_be = 2'($urandom);
      b_en = 1'($urandom); b_we = 1'($urandom);
      b_ad = 4'($urandom_range(15)); b_dat = 16'($urandom);
      b_be = 2'($urandom);
      if ($urandom_range(3) == 0) b_ad = a_ad;
      creq = ($urandom_range(59) == 0);
      rst = ($urandom_range(249) == 0);
      tick();
    end
    rst = 0;
    idle();
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
